// File: rtl/exec_ctrl_unit_pkg.sv
// exec_ctrl_unit_pkg: opcode, ALU, result and immediate encodings for the execute/control slice
package exec_ctrl_unit_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  // sub only when bit30 is set on a register-register op (bit5 distinguishes R from I)
  function automatic logic [2:0] alu_fn(input logic [2:0] funct3, input logic bit30, input logic bit5);
    return funct3 == 3'b000 ? ((bit30 && bit5) ? ALU_SUB : ALU_ADD) :
           funct3 == 3'b010 ? ALU_SLT :
           funct3 == 3'b100 ? ALU_XOR :
           funct3 == 3'b110 ? ALU_OR  :
           funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  endfunction
endpackage

// File: rtl/exec_ctrl_unit_adder.sv
// exec_adder: plain WIDTH-bit wrapping adder
module exec_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: single-cycle RV32 decoder, ALU, PC adders and next-PC select
module exec_ctrl_unit
  import exec_ctrl_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int PC_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [BUS_WIDTH-1:0] read_data_1,
  input  logic [BUS_WIDTH-1:0] read_data_2,
  input  logic [BUS_WIDTH-1:0] imm_ext,
  output logic [BUS_WIDTH-1:0] alu_result,
  output logic                 zero,
  output logic [BUS_WIDTH-1:0] src_b,
  output logic [PC_WIDTH-1:0]  pc_4,
  output logic [BUS_WIDTH-1:0] pc_target,
  output logic [PC_WIDTH-1:0]  pc_next,
  output logic                 pc_src,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 illegal_instr,
  output logic                 illegal_seen
);
  logic                 branch;
  logic                 jump;
  logic [2:0]           funct_op;
  logic [BUS_WIDTH-1:0] pc_ext;
  logic [PC_WIDTH-1:0]  four;
  assign funct_op = alu_fn(instr[14:12], instr[30], instr[5]);
  // main decode: one strobe set per supported opcode, everything else flagged illegal
  always_comb begin
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    alu_src       = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    result_src    = RES_ALU;
    imm_src       = IMM_I;
    alu_control   = ALU_ADD;
    illegal_instr = 1'b0;
    case (instr[6:0])
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
      end
      OP_R: begin
        reg_write   = 1'b1;
        alu_control = funct_op;
      end
      OP_I: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = funct_op;
      end
      OP_BRANCH: begin
        branch      = 1'b1;
        imm_src     = IMM_B;
        alu_control = ALU_SUB;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
      end
      default: illegal_instr = 1'b1;
    endcase
  end
  assign src_b = alu_src ? imm_ext : read_data_2;
  // ALU: unused encodings fall through to zero
  always_comb begin
    alu_result = alu_control == ALU_ADD ? read_data_1 + src_b :
                 alu_control == ALU_SUB ? read_data_1 - src_b :
                 alu_control == ALU_AND ? read_data_1 & src_b :
                 alu_control == ALU_OR  ? read_data_1 | src_b :
                 alu_control == ALU_XOR ? read_data_1 ^ src_b :
                 alu_control == ALU_SLT ? BUS_WIDTH'($signed(read_data_1) < $signed(src_b)) :
                 '0;
  end
  assign zero   = alu_result == '0;
  assign pc_src = jump | (branch & (zero ^ instr[12]));
  assign pc_ext = BUS_WIDTH'(pc);
  assign four   = PC_WIDTH'(4);
  exec_adder #(.WIDTH(PC_WIDTH)) u_pc_4 (
    .a(pc),
    .b(four),
    .y(pc_4)
  );
  exec_adder #(.WIDTH(BUS_WIDTH)) u_pc_target (
    .a(pc_ext),
    .b(imm_ext),
    .y(pc_target)
  );
  assign pc_next = pc_src ? pc_target[PC_WIDTH-1:0] : pc_4;
  // sticky illegal-instruction flag, only a reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_seen <= 1'b0;
    else if (illegal_instr) illegal_seen <= 1'b1;
  end
endmodule

// File: tb/tb_exec_ctrl_unit.sv
// tb_exec_ctrl_unit: directed table, illegal-flag sequence and randomized model check
module tb_exec_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, read_data_1, read_data_2, imm_ext;
  logic [15:0] pc;
  logic [31:0] alu_result, src_b, pc_target;
  logic [15:0] pc_4, pc_next;
  logic        zero, pc_src, mem_write, alu_src, reg_write, illegal_instr, illegal_seen;
  logic [1:0]  result_src;
  logic [2:0]  imm_src, alu_control;
  logic [12:0] ctrl;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign ctrl = {pc_src, mem_write, alu_src, reg_write, result_src, imm_src, alu_control, illegal_instr};
  exec_ctrl_unit #(.BUS_WIDTH(32), .PC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .imm_ext(imm_ext),
    .alu_result(alu_result), .zero(zero), .src_b(src_b), .pc_4(pc_4),
    .pc_target(pc_target), .pc_next(pc_next), .pc_src(pc_src),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .illegal_seen(illegal_seen)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
    logic [31:0] a, b, imm;
    logic [31:0] alu;
    logic [15:0] next;
    logic [12:0] ctrl;
  } vec_t;
  typedef struct {
    logic [31:0] alu, srcb, tgt;
    logic [15:0] next;
    logic [12:0] ctrl;
  } exp_t;
  function automatic exp_t model(input logic [31:0] i, input logic [15:0] p,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3, code, isrc;
    logic [1:0] rsrc;
    logic ld, st, r, ia, br, jl, usei, taken;
    logic [31:0] opnd, res;
    op = i[6:0];
    f3 = i[14:12];
    ld = op == 7'h03; st = op == 7'h23; r = op == 7'h33;
    ia = op == 7'h13; br = op == 7'h63; jl = op == 7'h6F;
    usei = ld | st | ia;
    opnd = usei ? imm : b;
    code = 3'd0;
    if (br) code = 3'd1;
    else if (r || ia)
      case (f3)
        3'd0: code = (r && i[30]) ? 3'd1 : 3'd0;
        3'd2: code = 3'd5;
        3'd4: code = 3'd4;
        3'd6: code = 3'd3;
        3'd7: code = 3'd2;
        default: code = 3'd0;
      endcase
    case (code)
      3'd0: res = a + opnd;
      3'd1: res = a - opnd;
      3'd2: res = a & opnd;
      3'd3: res = a | opnd;
      3'd4: res = a ^ opnd;
      default: res = ($signed(a) < $signed(opnd)) ? 32'd1 : 32'd0;
    endcase
    taken = jl | (br & ((res == 0) != f3[0]));
    e.alu  = res;
    e.srcb = opnd;
    e.tgt  = {16'h0, p} + imm;
    e.next = taken ? e.tgt[15:0] : p + 16'd4;
    rsrc = ld ? 2'd1 : jl ? 2'd2 : 2'd0;
    isrc = st ? 3'd1 : br ? 3'd2 : jl ? 3'd3 : 3'd0;
    e.ctrl = {taken, st, usei, ld | r | ia | jl, rsrc, isrc, code, ~(ld | st | r | ia | br | jl)};
    return e;
  endfunction
  vec_t vecs[15];
  logic [6:0] ops[6];
  exp_t e;
  initial begin
    vecs[0]  = '{32'h002081B3, 16'h0100, 32'd5, 32'd7, 32'd0, 32'd12, 16'h0104, 13'b0_0_0_1_00_000_000_0};
    vecs[1]  = '{32'h402081B3, 16'h0200, 32'h1234, 32'h1234, 32'd0, 32'd0, 16'h0204, 13'b0_0_0_1_00_000_001_0};
    vecs[2]  = '{32'h0020A1B3, 16'h0300, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 16'h0304, 13'b0_0_0_1_00_000_101_0};
    vecs[3]  = '{32'h00208463, 16'h0010, 32'd9, 32'd9, 32'd8, 32'd0, 16'h0018, 13'b1_0_0_0_00_010_001_0};
    vecs[4]  = '{32'h00208463, 16'h0010, 32'd9, 32'd3, 32'd8, 32'd6, 16'h0014, 13'b0_0_0_0_00_010_001_0};
    vecs[5]  = '{32'h00209463, 16'h0010, 32'd9, 32'd3, 32'd8, 32'd6, 16'h0018, 13'b1_0_0_0_00_010_001_0};
    vecs[6]  = '{32'h0020A223, 16'h0030, 32'h2000, 32'hAB, 32'd4, 32'h2004, 16'h0034, 13'b0_1_1_0_00_001_000_0};
    vecs[7]  = '{32'h0040A183, 16'h0040, 32'h2000, 32'hAB, 32'd4, 32'h2004, 16'h0044, 13'b0_0_1_1_01_000_000_0};
    vecs[8]  = '{32'h008000EF, 16'hFFFC, 32'd0, 32'd0, 32'd8, 32'd0, 16'h0004, 13'b1_0_0_1_10_011_000_0};
    vecs[9]  = '{32'h0000007F, 16'h0050, 32'd1, 32'd2, 32'd0, 32'd3, 16'h0054, 13'b0_0_0_0_00_000_000_1};
    vecs[10] = '{32'h40008093, 16'h0060, 32'd10, 32'd0, 32'h400, 32'h40A, 16'h0064, 13'b0_0_1_1_00_000_000_0};
    vecs[11] = '{32'h0000C093, 16'h0070, 32'hF0F0, 32'd0, 32'hFF, 32'hF00F, 16'h0074, 13'b0_0_1_1_00_000_100_0};
    vecs[12] = '{32'h0000E093, 16'h0080, 32'hF0, 32'd0, 32'h0F, 32'hFF, 16'h0084, 13'b0_0_1_1_00_000_011_0};
    vecs[13] = '{32'h0000F093, 16'h0090, 32'hF0, 32'd0, 32'h3C, 32'h30, 16'h0094, 13'b0_0_1_1_00_000_010_0};
    vecs[14] = '{32'h002091B3, 16'h00A0, 32'd1, 32'd2, 32'd0, 32'd3, 16'h00A4, 13'b0_0_0_1_00_000_000_0};
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
    rst_n = 1'b0;
    instr = 32'h0000007F;
    pc = 16'h0; read_data_1 = 0; read_data_2 = 0; imm_ext = 0;
    #1 chk("reset_seen", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk); #1 chk("reset_hold_seen", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk); rst_n = 1'b1; instr = 32'h002081B3;
    @(posedge clk); #1 chk("legal_no_seen", {31'd0, illegal_seen}, 32'd0);
    instr = 32'h0000007F;
    #1 chk("illegal_comb", {31'd0, illegal_instr}, 32'd1);
    chk("seen_before_edge", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk); #1 chk("seen_set", {31'd0, illegal_seen}, 32'd1);
    instr = 32'h002081B3;
    @(posedge clk); #1 chk("seen_sticky", {31'd0, illegal_seen}, 32'd1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk("async_clear", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      instr = vecs[k].instr; pc = vecs[k].pc;
      read_data_1 = vecs[k].a; read_data_2 = vecs[k].b; imm_ext = vecs[k].imm;
      #1;
      chk($sformatf("v%0d_alu", k), alu_result, vecs[k].alu);
      chk($sformatf("v%0d_zero", k), {31'd0, zero}, {31'd0, vecs[k].alu == 0});
      chk($sformatf("v%0d_pc_next", k), {16'd0, pc_next}, {16'd0, vecs[k].next});
      chk($sformatf("v%0d_pc_4", k), {16'd0, pc_4}, {16'd0, vecs[k].pc + 16'd4});
      chk($sformatf("v%0d_ctrl", k), {19'd0, ctrl}, {19'd0, vecs[k].ctrl});
    end
    instr = vecs[8].instr; pc = 16'hFFFC; imm_ext = 32'd8;
    #1 chk("jal_pc_target", pc_target, 32'h0001_0004);
    instr = vecs[6].instr; imm_ext = 32'd4; read_data_2 = 32'hAB;
    #1 chk("sw_src_b", src_b, 32'd4);
    for (int k = 0; k < 300; k++) begin
      instr = $urandom();
      if (k % 7 != 0) instr[6:0] = ops[$urandom_range(5)];
      pc = 16'($urandom());
      read_data_1 = $urandom();
      read_data_2 = (k % 4 == 0) ? read_data_1 : $urandom();
      imm_ext = (k % 3 == 0) ? 32'($signed(12'($urandom()))) : $urandom();
      #1;
      e = model(instr, pc, read_data_1, read_data_2, imm_ext);
      chk($sformatf("r%0d_alu", k), alu_result, e.alu);
      chk($sformatf("r%0d_src_b", k), src_b, e.srcb);
      chk($sformatf("r%0d_pc_target", k), pc_target, e.tgt);
      chk($sformatf("r%0d_pc_next", k), {16'd0, pc_next}, {16'd0, e.next});
      chk($sformatf("r%0d_ctrl", k), {19'd0, ctrl}, {19'd0, e.ctrl});
      chk($sformatf("r%0d_zero", k), {31'd0, zero}, {31'd0, e.alu == 0});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
